// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Purpose:
//   Shared definitions for the memory port arbiter slice: the arbiter FSM
//   state encoding, the transaction owner encoding and a few width constants.
//   The optional fetch-fairness feature is controlled by the macro
//   MEM_ARB_FAIR_EN, which is consumed by mem_arb_grant and mem_port_arbiter.
//
// Contents:
//   arb_state_t  - ARB_IDLE / ARB_ADDR / ARB_WAIT (2 bits)
//   owner_t      - OWN_NONE / OWN_INST / OWN_DATA (2 bits)
//   WSTRB_W      - byte-enable width of the data and bus ports
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int WSTRB_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
//
// Purpose:
//   Winner selection between the fetch requester and the data requester.
//   By default data strictly beats fetch. When MEM_ARB_FAIR_EN is defined a
//   saturating counter tracks consecutive data grants made while fetch was
//   waiting; once it reaches STARVE_MAX the next grant goes to fetch.
//
// Parameters:
//   STARVE_MAX - data grants tolerated while fetch waits (fairness build only)
//
// Ports:
//   clk, rst    - clock / async active-high reset (fairness build only)
//   inst_req    - fetch request pending
//   data_req    - data request pending
//   grant_en    - a grant is being taken this cycle (fairness build only)
//   grant_inst  - fetch wins if a grant is taken this cycle
//   grant_data  - data wins if a grant is taken this cycle
//
// Configuration macro: MEM_ARB_FAIR_EN
// -----------------------------------------------------------------------------
module mem_arb_grant
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
`ifdef MEM_ARB_FAIR_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
`endif
    input  logic inst_req,
    input  logic data_req,
    output logic grant_inst,
    output logic grant_data
);

`ifdef MEM_ARB_FAIR_EN

    // A STARVE_MAX below 1 still needs a 1-bit counter to stay legal.
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_forced;

    assign fetch_forced = (starve_cnt == CNT_W'(STARVE_MAX));

    // Data still wins unless fetch has been passed over too many times.
    assign grant_data = data_req && !(inst_req && fetch_forced);
    assign grant_inst = inst_req && !grant_data;

    // The count only moves when a grant is actually taken. A data grant with
    // no fetch waiting breaks the run of consecutive starving grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_en) begin
            if (grant_inst) begin
                starve_cnt <= '0;
            end else if (grant_data) begin
                if (!inst_req) begin
                    starve_cnt <= '0;
                end else if (!fetch_forced) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end
        end
    end

`else

    assign grant_data = data_req;
    assign grant_inst = inst_req && !data_req;

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one SRAM-like memory port between instruction fetch and the data
//   (mem stage) requester. One transaction is outstanding at a time, carried
//   through a request / address-accept / data-return handshake. Data has
//   priority over fetch; per-requester stall requests go to the pipeline
//   stall controller.
//
// Parameters:
//   ADDR_W     - address width
//   DATA_W     - data width
//   STARVE_MAX - data grants tolerated while fetch waits (MEM_ARB_FAIR_EN only)
//
// Ports:
//   clk, rst                          - clock, async active-high reset
//   inst_req/inst_addr                - fetch request (held until inst_addr_ok)
//   inst_addr_ok/inst_data_ok/inst_rdata - fetch accept, data pulse, read data
//   data_req/data_wr/data_wstrb/data_addr/data_wdata - data request
//   data_addr_ok/data_data_ok/data_rdata - data accept, done pulse, read data
//   bus_req/bus_wr/bus_wstrb/bus_addr/bus_wdata - memory request (registered)
//   bus_addr_ok/bus_data_ok/bus_rdata - memory accept, data/ack, read data
//   stallreq_if/stallreq_mem          - stall requests for fetch / mem stage
//
// Configuration macro: MEM_ARB_FAIR_EN enables fetch starvation protection.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
)
(
    input  logic               clk,
    input  logic               rst,

    input  logic               inst_req,
    input  logic [ADDR_W-1:0]  inst_addr,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [DATA_W-1:0]  inst_rdata,

    input  logic               data_req,
    input  logic               data_wr,
    input  logic [WSTRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]  data_addr,
    input  logic [DATA_W-1:0]  data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [DATA_W-1:0]  data_rdata,

    output logic               bus_req,
    output logic               bus_wr,
    output logic [WSTRB_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]  bus_addr,
    output logic [DATA_W-1:0]  bus_wdata,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    input  logic [DATA_W-1:0]  bus_rdata,

    output logic               stallreq_if,
    output logic               stallreq_mem
);

    arb_state_t state;
    owner_t     owner;

    logic               addr_accept;
    logic               data_done;
    logic               grant_en;
    logic               grant_inst;
    logic               grant_data;
    logic               start_txn;

    logic               win_wr;
    logic [WSTRB_W-1:0] win_wstrb;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    owner_t             win_owner;

    assign addr_accept = (state == ARB_ADDR) && bus_addr_ok;
    assign data_done   = (state == ARB_WAIT) && bus_data_ok;

    // Grants are taken from IDLE, or directly in the data-return cycle so
    // back-to-back transactions need no idle bubble.
    assign grant_en  = (state == ARB_IDLE) || data_done;
    assign start_txn = grant_en && (grant_inst || grant_data);

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
`ifdef MEM_ARB_FAIR_EN
        .clk        (clk),
        .rst        (rst),
        .grant_en   (grant_en),
`endif
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    // Fields of the winning requester; fetch is always a plain read.
    always_comb begin
        win_wr    = 1'b0;
        win_wstrb = '0;
        win_addr  = inst_addr;
        win_wdata = '0;
        win_owner = OWN_INST;
        if (grant_data) begin
            win_wr    = data_wr;
            win_wstrb = data_wstrb;
            win_addr  = data_addr;
            win_wdata = data_wdata;
            win_owner = OWN_DATA;
        end
    end

    // Arbiter FSM. Requester inputs are sampled only at grant; the bus
    // fields then stay frozen until the next grant, so a requester changing
    // its inputs mid-flight cannot disturb the transaction. A bus_data_ok
    // outside WAIT is simply not looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= OWN_NONE;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (start_txn) begin
                        state     <= ARB_ADDR;
                        owner     <= win_owner;
                        bus_req   <= 1'b1;
                        bus_wr    <= win_wr;
                        bus_wstrb <= win_wstrb;
                        bus_addr  <= win_addr;
                        bus_wdata <= win_wdata;
                    end
                end
                ARB_ADDR: begin
                    if (bus_addr_ok) begin
                        state   <= ARB_WAIT;
                        bus_req <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (bus_data_ok) begin
                        if (start_txn) begin
                            state     <= ARB_ADDR;
                            owner     <= win_owner;
                            bus_req   <= 1'b1;
                            bus_wr    <= win_wr;
                            bus_wstrb <= win_wstrb;
                            bus_addr  <= win_addr;
                            bus_wdata <= win_wdata;
                        end else begin
                            state <= ARB_IDLE;
                            owner <= OWN_NONE;
                        end
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    owner   <= OWN_NONE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Handshake pulses are routed to the current owner in the same cycle as
    // the memory's response; with no owner nothing is ever signalled.
    assign inst_addr_ok = addr_accept && (owner == OWN_INST);
    assign data_addr_ok = addr_accept && (owner == OWN_DATA);
    assign inst_data_ok = data_done && (owner == OWN_INST);
    assign data_data_ok = data_done && (owner == OWN_DATA);

    assign inst_rdata = (owner == OWN_INST) ? bus_rdata : '0;
    assign data_rdata = (owner == OWN_DATA) ? bus_rdata : '0;

    // A requester stalls while it asks or owns the port, released in the
    // cycle its data comes back.
    assign stallreq_if  = (inst_req || (owner == OWN_INST)) && !inst_data_ok;
    assign stallreq_mem = (data_req || (owner == OWN_DATA)) && !data_data_ok;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester (pc_reg/if_id side) and the data requester (mem stage). The block runs one transaction at a time through a request/address-accept/data-return handshake. It gives data priority over fetch and raises per-requester stall requests into the pipeline stall controller (ctrl). It sits between the core pipeline and the external memory interface.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (only used with fairness enabled)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted by bus
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  data request, held until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  4  byte enables (writes)
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data read returned / write done (1-cycle pulse)
- data_rdata  out  DATA_W  data read data
- bus_req  out  1  request to memory
- bus_wr  out  1  write flag
- bus_wstrb  out  4  byte enables
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  memory accepted request
- bus_data_ok  in  1  memory returned data / write ack
- bus_rdata  in  DATA_W  memory read data
- stallreq_if  out  1  stall request for fetch
- stallreq_mem  out  1  stall request for mem stage

## Operation
- FSM states: IDLE, ADDR, WAIT. Owner register: NONE, INST, DATA. Only one transaction is outstanding at a time.
- Grant in IDLE:
  - Any request present → latch the winner's wr/wstrb/addr/wdata into the bus registers, set owner, go to ADDR.
  - data_req beats inst_req.
- ADDR state:
  - bus_req = 1, driven from the latched registers.
  - On bus_addr_ok: pulse the owner's *_addr_ok in the same cycle (combinational) and go to WAIT.
- WAIT state:
  - bus_req = 0.
  - On bus_data_ok: the owner's *_data_ok = 1 and its *_rdata = bus_rdata (pass-through), same cycle.
  - If any request is pending in that same cycle, grant it directly (go to ADDR). Otherwise go to IDLE and set owner = NONE.
- Reads and writes share one flow. A write completes on bus_data_ok, and data_rdata is don't-care on writes.
- *_data_ok is never asserted when owner is NONE. A stray bus_data_ok in IDLE or ADDR is ignored.
- Stall requests:
  - stallreq_if = (inst_req | owner==INST) & ~inst_data_ok.
  - stallreq_mem = (data_req | owner==DATA) & ~data_data_ok.
- Requester inputs are sampled only at grant. Changes after grant do not affect the transaction in flight.

## Timing
- Reset values: FSM IDLE, owner NONE; bus_req/bus_wr 0; bus_wstrb/bus_addr/bus_wdata 0; all *_addr_ok/*_data_ok 0; *_rdata 0 (owner NONE gates the pass-through); stalls follow the requests combinationally.
- Minimum latency, request to data_ok: 2 cycles.
  - Request at cycle 0; bus_req from cycle 1.
  - bus_addr_ok at cycle 1 → WAIT at cycle 2.
  - bus_data_ok at cycle 2.
- Back-to-back transactions need no IDLE bubble: a grant in the data_ok cycle puts bus_req up on the next cycle.
- bus_addr_ok and bus_data_ok may stall for any number of cycles. bus_req stays asserted with stable fields until bus_addr_ok.
- Async reset mid-transaction abandons it. The memory side must be reset together with this block.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A saturating counter counts consecutive data grants made while inst_req is pending.
  - When the counter equals STARVE_MAX, the next grant goes to fetch even if data_req = 1.
  - The counter clears on any fetch grant and on reset.
- MEM_ARB_FAIR_EN undefined: strict data priority, and no counter is instantiated.

## Structure
- Shared defines header holds:
  - FSM state encodings (ARB_IDLE/ARB_ADDR/ARB_WAIT, 2 bits).
  - Owner encodings (OWN_NONE/OWN_INST/OWN_DATA).
- One sub-module, mem_arb_grant: combinational winner select plus, under MEM_ARB_FAIR_EN, the starvation counter.

## Test plan
- Single read: inst_req with inst_addr=0xBFC00000; memory acks addr at cycle 1 and returns data 0x3C1D0001 at cycle 2 → bus_addr=0xBFC00000, inst_data_ok pulse at cycle 2 with inst_rdata=0x3C1D0001, stallreq_if low at cycle 3.
- Conflict: inst_req and data_req (write, addr 0x80001000, wdata 0xDEADBEEF, wstrb 0xF) both rise at cycle 0 → data is granted first with bus_wr=1; fetch is granted in the data_ok cycle; stallreq_if stays high until inst_data_ok.
- Slow memory: bus_addr_ok delayed 5 cycles, bus_data_ok delayed 3 more → bus_req held with stable bus_addr; exactly one addr_ok and one data_ok pulse.
- Fairness (MEM_ARB_FAIR_EN, STARVE_MAX=4): data_req held continuously with inst_req pending → the 5th grant goes to fetch. Without the macro, fetch is never granted.
- Reset mid-WAIT: assert rst during WAIT, then bus_data_ok arrives after release → no *_data_ok pulse, FSM in IDLE, bus_req=0.
- Stray ack: bus_data_ok pulsed in IDLE → no outputs change.
